// File: rtl/fetch_stage.sv
// fetch_stage: LEGv8 instruction fetch unit with IF/ID pipeline register.
//
// Holds the PC and issues one word request at a time to instruction memory
// over a valid/ready handshake. The returned instruction and its PC are
// registered for the decode stage. Handles decode stalls, where an arriving
// word is parked in a hold buffer, and branch redirects, where any in-flight
// wrong-path response is discarded.
//
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   branch_taken    redirect request; branch_target is the new PC (word aligned)
//   id_stall        decode cannot accept; IF/ID register holds
//   imem_req/addr   request valid / address (equals the internal PC)
//   imem_ready      memory accepts the request this cycle
//   imem_rvalid     response valid (one per accepted request, in order)
//   imem_rdata      instruction word
//   if_valid/pc/instr  IF/ID register contents
module fetch_stage #(
  parameter int unsigned       ADDR_W   = 64,
  parameter int unsigned       INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               id_stall,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [INSTR_W-1:0] if_instr
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   pc, pc_n;
  logic [ADDR_W-1:0]   req_pc, req_pc_n;
  logic                discard, discard_n;
  logic                if_valid_n;
  logic [ADDR_W-1:0]   if_pc_n;
  logic [INSTR_W-1:0]  if_instr_n;
  // Hold buffer contents are meaningful only while in S_HOLD; leaving that
  // state is what drops them, so no separate valid bit is kept.
  logic [ADDR_W-1:0]   hold_pc, hold_pc_n;
  logic [INSTR_W-1:0]  hold_instr, hold_instr_n;

  assign imem_req  = (state == S_REQ);
  assign imem_addr = pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      req_pc     <= '0;
      discard    <= 1'b0;
      if_valid   <= 1'b0;
      if_pc      <= '0;
      if_instr   <= '0;
      hold_pc    <= '0;
      hold_instr <= '0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      req_pc     <= req_pc_n;
      discard    <= discard_n;
      if_valid   <= if_valid_n;
      if_pc      <= if_pc_n;
      if_instr   <= if_instr_n;
      hold_pc    <= hold_pc_n;
      hold_instr <= hold_instr_n;
    end
  end

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    req_pc_n     = req_pc;
    discard_n    = discard;
    // Consumed by decode unless stalled; a load below overrides this.
    if_valid_n   = id_stall ? if_valid : 1'b0;
    if_pc_n      = if_pc;
    if_instr_n   = if_instr;
    hold_pc_n    = hold_pc;
    hold_instr_n = hold_instr;

    if (branch_taken) begin
      pc_n         = branch_target & ~ADDR_W'(3);
      if_valid_n   = 1'b0;
      hold_pc_n    = '0;
      hold_instr_n = '0;
      case (state)
        S_IDLE: state_n = S_REQ;
        S_REQ: begin
          // The old-PC request was accepted this cycle; its response is stale.
          if (imem_ready) begin
            discard_n = 1'b1;
            state_n   = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            discard_n = 1'b0;
            state_n   = S_REQ;
          end else begin
            discard_n = 1'b1;
          end
        end
        S_HOLD:  state_n = S_REQ;
        default: state_n = S_IDLE;
      endcase
    end else begin
      case (state)
        S_IDLE: state_n = S_REQ;
        S_REQ: begin
          if (imem_ready) begin
            req_pc_n = pc;
            pc_n     = pc + ADDR_W'(4);
            state_n  = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (discard) begin
              discard_n = 1'b0;
              state_n   = S_REQ;
            end else if (!if_valid || !id_stall) begin
              if_valid_n = 1'b1;
              if_pc_n    = req_pc;
              if_instr_n = imem_rdata;
              state_n    = S_REQ;
            end else begin
              hold_pc_n    = req_pc;
              hold_instr_n = imem_rdata;
              state_n      = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!id_stall) begin
            if_valid_n = 1'b1;
            if_pc_n    = hold_pc;
            if_instr_n = hold_instr;
            state_n    = S_REQ;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed sequences for the stall, redirect,
// wrap and reset corners, a table of redirect targets, then randomized
// stall/redirect/memory timing checked against a program-order scoreboard.
module tb_fetch_stage;
  localparam int unsigned ADDR_W   = 64;
  localparam int unsigned INSTR_W  = 32;
  localparam logic [63:0] RESET_PC = 64'h0;

  logic               clk = 1'b0;
  logic               reset;
  logic               branch_taken;
  logic [ADDR_W-1:0]  branch_target;
  logic               id_stall;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ready;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;
  logic               if_valid;
  logic [ADDR_W-1:0]  if_pc;
  logic [INSTR_W-1:0] if_instr;

  always #5 clk = ~clk;

  fetch_stage #(
    .ADDR_W(ADDR_W),
    .INSTR_W(INSTR_W),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .branch_taken(branch_taken),
    .branch_target(branch_target),
    .id_stall(id_stall),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .if_valid(if_valid),
    .if_pc(if_pc),
    .if_instr(if_instr)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory image: fixed words at 0 and 4, a hash of the address elsewhere.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == 64'h0) return 32'hF84003E1;
    if (a == 64'h4) return 32'h91000421;
    return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h5A5A0000;
  endfunction

  // Memory model: one outstanding request, response after dly cycles.
  bit          pend;
  logic [63:0] paddr;
  int          dly;
  int          rdy_pct = 100, dly_min = 0, dly_max = 0;
  bit          accepted;
  logic [63:0] acc_addr;

  // Scoreboard: instructions leave IF/ID in program order from exp_pc.
  logic [63:0] exp_pc;
  int          cons_n = 0;
  int          cyc = 0;
  int          cons_cyc_q[$];
  bit          p_br, p_hold, p_reqwait;
  logic [63:0] p_pc, p_addr;
  logic [31:0] p_instr;

  task automatic clear_prev();
    p_br = 0; p_hold = 0; p_reqwait = 0;
  endtask

  // Called at a negedge with id_stall/branch_* already set for this cycle.
  task automatic cycle();
    chk("one_outstanding", 64'(pend & imem_req), 0);
    if (p_br) chk("flush_valid", if_valid, 0);
    if (p_hold) begin
      chk("stall_valid", if_valid, 1);
      chk("stall_pc", if_pc, p_pc);
      chk("stall_instr", if_instr, p_instr);
    end
    if (p_reqwait) begin
      chk("req_held", imem_req, 1);
      chk("addr_stable", imem_addr, p_addr);
    end
    accepted = 0;
    imem_ready = ($urandom_range(99) < rdy_pct);
    if (pend) begin
      if (dly == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(paddr);
        pend        = 0;
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        dly--;
      end
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      if (imem_req && imem_ready) begin
        pend     = 1;
        paddr    = imem_addr;
        dly      = $urandom_range(dly_max, dly_min);
        accepted = 1;
        acc_addr = imem_addr;
      end
    end
    if (branch_taken) begin
      exp_pc = branch_target & ~64'h3;
    end else if (if_valid && !id_stall) begin
      chk("if_pc_order", if_pc, exp_pc);
      chk("if_instr", 64'(if_instr), 64'(mem_word(if_pc)));
      exp_pc += 64'd4;
      cons_n++;
      cons_cyc_q.push_back(cyc);
    end
    p_br      = branch_taken;
    p_hold    = if_valid && id_stall && !branch_taken;
    p_pc      = if_pc;
    p_instr   = if_instr;
    p_reqwait = imem_req && !imem_ready && !branch_taken;
    p_addr    = imem_addr;
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_req(input string name);
    for (int i = 0; i < 20 && !imem_req; i++) cycle();
    chk(name, imem_req, 1);
  endtask

  task automatic wait_accept(input string name);
    int n = 0;
    do begin
      cycle();
      n++;
    end while (!accepted && n < 20);
    chk(name, accepted, 1);
  endtask

  typedef struct {
    logic [63:0] target;
    logic [63:0] exp_addr;
  } vec_t;

  initial begin
    vec_t        tbl[4];
    logic [63:0] a;
    int          reqcnt;
    int          n;

    tbl[0] = '{target: 64'h0000_0000_0000_1002, exp_addr: 64'h0000_0000_0000_1000};
    tbl[1] = '{target: 64'h0000_0000_0000_0007, exp_addr: 64'h0000_0000_0000_0004};
    tbl[2] = '{target: 64'h8000_0000_0000_0010, exp_addr: 64'h8000_0000_0000_0010};
    tbl[3] = '{target: 64'hFFFF_FFFF_FFFF_FFFF, exp_addr: 64'hFFFF_FFFF_FFFF_FFFC};

    reset = 1'b1; branch_taken = 1'b0; branch_target = '0; id_stall = 1'b0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    pend = 0; exp_pc = RESET_PC; clear_prev();
    repeat (2) @(negedge clk);
    chk("rst_if_valid", if_valid, 0);
    chk("rst_if_pc", if_pc, 0);
    chk("rst_if_instr", 64'(if_instr), 0);
    chk("rst_imem_req", imem_req, 0);
    chk("rst_imem_addr", imem_addr, RESET_PC);
    reset = 1'b0;

    // Reset release, always-ready memory, response one cycle after accept.
    cons_n = 0;
    cons_cyc_q.delete();
    repeat (8) cycle();
    chk("seq1_count", 64'(cons_n >= 2), 1);
    if (cons_cyc_q.size() >= 2) chk("seq1_gap", 64'(cons_cyc_q[1] - cons_cyc_q[0]), 2);

    // Stall for 5 cycles while the next response arrives.
    n = 0;
    while (!if_valid && n < 20) begin cycle(); n++; end
    chk("seq2_valid", if_valid, 1);
    a = if_pc;
    id_stall = 1'b1;
    reqcnt = 0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) reqcnt += int'(imem_req);
      cycle();
    end
    chk("seq2_no_req_in_hold", 64'(reqcnt), 0);
    id_stall = 1'b0;
    cycle();
    chk("seq2_buf_valid", if_valid, 1);
    chk("seq2_buf_pc", if_pc, a + 64'd4);
    chk("seq2_no_refetch_req", imem_req, 1);
    chk("seq2_no_refetch_addr", imem_addr, a + 64'd8);

    // Redirect while a response is pending (arrives two cycles later).
    dly_min = 2; dly_max = 2;
    wait_accept("seq3_accept");
    branch_taken = 1'b1; branch_target = 64'h1002;
    cycle();
    branch_taken = 1'b0;
    n = 0;
    do begin
      chk("seq3_no_valid", if_valid, 0);
      cycle();
      n++;
    end while (!accepted && n < 20);
    chk("seq3_accept2", accepted, 1);
    chk("seq3_target_addr", acc_addr, 64'h1000);
    dly_min = 0; dly_max = 0;
    repeat (6) cycle();

    // Redirect in the same cycle the request at 0x8 is accepted.
    rdy_pct = 0;
    wait_req("seq4_req");
    branch_taken = 1'b1; branch_target = 64'h8;
    cycle();
    branch_taken = 1'b0;
    chk("seq4_at8_req", imem_req, 1);
    chk("seq4_at8_addr", imem_addr, 64'h8);
    rdy_pct = 100;
    branch_taken = 1'b1; branch_target = 64'h2000;
    cycle();
    branch_taken = 1'b0;
    wait_accept("seq4_accept");
    chk("seq4_target_addr", acc_addr, 64'h2000);
    repeat (6) cycle();

    // Redirect target alignment table; last entry also exercises PC wrap.
    foreach (tbl[i]) begin
      rdy_pct = 0;
      wait_req("tbl_req");
      branch_taken = 1'b1; branch_target = tbl[i].target;
      cycle();
      branch_taken = 1'b0;
      chk("tbl_req_after", imem_req, 1);
      chk("tbl_addr", imem_addr, tbl[i].exp_addr);
    end
    rdy_pct = 100;
    cycle();
    chk("wrap_accept", accepted, 1);
    wait_req("wrap_req");
    chk("wrap_addr", imem_addr, 64'h0);
    repeat (6) cycle();

    // Asynchronous reset in S_WAIT with the response landing during reset.
    dly_min = 3; dly_max = 3;
    wait_accept("seq6_accept");
    #2 reset = 1'b1;
    imem_rvalid = 1'b1; imem_rdata = 32'hDEADBEEF;
    #1;
    chk("seq6_rst_valid", if_valid, 0);
    chk("seq6_rst_pc", if_pc, 0);
    chk("seq6_rst_instr", 64'(if_instr), 0);
    chk("seq6_rst_req", imem_req, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    imem_rvalid = 1'b0;
    pend = 0; exp_pc = RESET_PC; clear_prev();
    reset = 1'b0;
    chk("seq6_post_valid", if_valid, 0);
    dly_min = 0; dly_max = 0;
    wait_req("seq6_req");
    chk("seq6_first_addr", imem_addr, RESET_PC);
    repeat (6) cycle();

    // Randomized stall/redirect/memory timing.
    rdy_pct = 60; dly_min = 0; dly_max = 3;
    n = cons_n;
    for (int i = 0; i < 4000; i++) begin
      id_stall      = ($urandom_range(99) < 30);
      branch_taken  = ($urandom_range(99) < 3);
      branch_target = {$urandom, $urandom};
      cycle();
    end
    id_stall = 1'b0; branch_taken = 1'b0;
    repeat (20) cycle();
    chk("rand_progress", 64'((cons_n - n) > 100), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch unit plus IF/ID pipeline register for the LEGv8 datapath.
- Holds the PC and issues one word request at a time to instruction memory over a valid/ready handshake.
- Registers the returned 32-bit instruction with its PC for the decode stage, where the immediate sign extender consumes if_instr.
- Handles decode stalls and branch redirects, including discarding in-flight wrong-path responses.

Parameters:
- ADDR_W, 64, width of PC and memory address.
- INSTR_W, 32, instruction word width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- branch_taken  in  1  redirect request from the branch unit.
- branch_target  in  ADDR_W  redirect PC.
- id_stall  in  1  decode cannot accept; hold the IF/ID register.
- imem_req  out  1  request valid.
- imem_addr  out  ADDR_W  request address; equals the internal pc.
- imem_ready  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  response valid; one response per accepted request, in order.
- imem_rdata  in  INSTR_W  instruction word.
- if_valid  out  1  IF/ID register holds a valid instruction.
- if_pc  out  ADDR_W  PC of if_instr.
- if_instr  out  INSTR_W  instruction to decode/sign-extend.

Behaviour:
- Reset (async): state=S_IDLE, pc=RESET_PC, discard=0, if_valid=0, if_pc=0, if_instr=0, hold buffer cleared. imem_req=0 while in reset.
- FSM states: S_IDLE, S_REQ, S_WAIT, S_HOLD.
- S_IDLE: leaves unconditionally to S_REQ on the first clock after reset deasserts.
- S_REQ: imem_req=1. On imem_ready: req_pc<=pc, pc<=pc+4 (mod 2^ADDR_W, wraps), next state S_WAIT.
- S_WAIT: imem_req=0. On imem_rvalid:
  - discard=1: drop data, clear discard, go to S_REQ.
  - Output slot free (if_valid==0 or id_stall==0): if_valid<=1, if_pc<=req_pc, if_instr<=imem_rdata, go to S_REQ.
  - Slot occupied and stalled: capture into the hold buffer, go to S_HOLD.
- S_HOLD: when id_stall==0, move the hold buffer into the IF/ID register (if_valid<=1) and go to S_REQ.
- IF/ID register:
  - If id_stall==0 and nothing is loaded this cycle, if_valid<=0.
  - If id_stall==1, if_valid/if_pc/if_instr hold unchanged.
- Redirect (branch_taken==1): highest priority, overrides id_stall and all loads.
  - pc<=branch_target with bits[1:0] forced to 0.
  - if_valid<=0; hold buffer dropped.
  - S_REQ without imem_ready: stay in S_REQ, new pc is used next cycle.
  - S_REQ with imem_ready same cycle: the old-pc request was accepted, so set discard=1 and go to S_WAIT; pc still takes the target.
  - S_WAIT with imem_rvalid same cycle: drop the response, go to S_REQ.
  - S_WAIT without imem_rvalid: set discard=1, stay in S_WAIT.
  - S_HOLD: go to S_REQ.
  - S_IDLE: pc takes the target.
- Latency: with imem_ready=1 and imem_rvalid one cycle after acceptance, if_valid rises 2 cycles after the request is accepted. Steady-state throughput is one instruction per 2 cycles.
- At most one outstanding request. imem_addr stays stable while imem_req=1 and imem_ready=0.
- Reset mid-transaction: all state is discarded; any late response is ignored because the FSM is in S_IDLE/S_REQ, not S_WAIT.

Test Plan:
- Reset release with RESET_PC=0, memory always ready, rvalid 1 cycle later, words 0xF84003E1, 0x91000421 -> if_pc 0 then 4, if_instr matches, if_valid pulses each 2 cycles.
- id_stall=1 for 5 cycles while a response arrives -> if_* frozen on the older instruction. FSM sits in S_HOLD with the new word buffered, imem_req=0. After release, the buffered word appears on the next edge with no refetch.
- branch_taken with target 0x1002 while in S_WAIT (response pending, arrives 2 cycles later) -> pending word dropped, next imem_addr=0x1000, if_valid stays 0 until the 0x1000 word returns.
- branch_taken in the same cycle as imem_ready in S_REQ at pc=0x8 -> the 0x8 response is discarded, next request is the target, and 0x8 never reaches if_*.
- pc=0xFFFFFFFFFFFFFFFC accepted -> next imem_addr=0x0.
- Async reset asserted mid-S_WAIT, rvalid arrives during reset -> outputs zero, no instruction latched, first post-reset imem_addr=RESET_PC.
